luma_class_estimator: RTL and testbench

LUMA_CLASS_ESTIMATOR -- requirements
Module: luma_class_estimator

---
 rtl/luma_class_estimator_pkg.sv | 32 +++
 rtl/luma_class_estimator_if.sv | 36 +++
 rtl/luma_class_estimator_divider.sv | 66 ++++++
 rtl/luma_class_estimator.sv | 190 +++++++++++++++++++
 tb/tb_luma_class_estimator.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/luma_class_estimator_pkg.sv
// ---------------------------------------------------------------------------
// luma_class_estimator_pkg
// Shared definitions for the two-class luma estimator: FSM state encoding,
// default image geometry, datapath widths and the threshold helper.
// ---------------------------------------------------------------------------
package luma_class_estimator_pkg;

   localparam int DEF_IMAGE_WIDTH = 384;
   localparam int DEF_IMAGE_HIGHT = 216;

   localparam int LUMA_W    = 8;
   localparam int SUM_W     = 25;   // 255 * 82944 < 2^25
   localparam int CNT_W     = 17;   // 82944 < 2^17
   localparam int DIV_ITERS = 8;    // one quotient bit per iteration
   localparam int DIV_HOLD  = DIV_ITERS + 1;  // start cycle + iterations

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DIV_1,
      ST_DIV_2,
      ST_UPDATE
   } state_t;

   // Midpoint of the two class means, built from truncated halves so the
   // sum always fits in LUMA_W+1 bits.
   function automatic logic [LUMA_W:0] threshold(input logic [LUMA_W-1:0] c1,
                                                 input logic [LUMA_W-1:0] c2);
      return {2'b00, c1[LUMA_W-1:1]} + {2'b00, c2[LUMA_W-1:1]};
   endfunction

endpackage

// File: rtl/luma_class_estimator_if.sv
// ---------------------------------------------------------------------------
// luma_class_estimator_if
// Pixel stream in, class estimate out.
//   luma_ch      8  luma sample, qualified by pixel_valid
//   pixel_valid  1  luma_ch carries an active pixel
//   frame_start  1  first pixel of a frame (only with pixel_valid)
//   class_1      8  dark-class mean
//   class_2      8  bright-class mean
//   class_valid  1  sticky: first estimate produced
//   converged    1  last update left both means unchanged
//   busy         1  estimator not idle
// master = pixel source / result consumer, slave = estimator.
// ---------------------------------------------------------------------------
interface luma_class_estimator_if;
   import luma_class_estimator_pkg::*;

   logic [LUMA_W-1:0] luma_ch;
   logic              pixel_valid;
   logic              frame_start;
   logic [LUMA_W-1:0] class_1;
   logic [LUMA_W-1:0] class_2;
   logic              class_valid;
   logic              converged;
   logic              busy;

   modport master (
      output luma_ch, pixel_valid, frame_start,
      input  class_1, class_2, class_valid, converged, busy
   );

   modport slave (
      input  luma_ch, pixel_valid, frame_start,
      output class_1, class_2, class_valid, converged, busy
   );

endinterface

// File: rtl/luma_class_estimator_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
// Restoring divider producing an 8-bit truncated quotient, one bit per cycle.
// The caller guarantees dividend/divisor < 256 (a mean of 8-bit samples).
//   clk, rst   clock, asynchronous active-high reset
//   start      load operands on this edge
//   dividend   SUM_W-bit numerator
//   divisor    CNT_W-bit denominator (non-zero when start is used)
//   quotient   8-bit result, valid while done is high and until next start
//   done       one-cycle pulse, 8 cycles after the start edge
// ---------------------------------------------------------------------------
module serial_divider
   import luma_class_estimator_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SUM_W-1:0]  dividend,
   input  logic [CNT_W-1:0]  divisor,
   output logic [LUMA_W-1:0] quotient,
   output logic              done
);

   logic [SUM_W-1:0] rem;
   logic [CNT_W-1:0] dvs;
   logic [2:0]       idx;       // quotient bit resolved this iteration
   logic             running;
   logic [SUM_W-1:0] trial;

   // divisor << idx never exceeds CNT_W+7 bits, so it fits in SUM_W.
   assign trial = {{(SUM_W-CNT_W){1'b0}}, dvs} << idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= '0;
         dvs      <= '0;
         idx      <= '0;
         running  <= 1'b0;
         quotient <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= dividend;
            dvs      <= divisor;
            quotient <= '0;
            idx      <= 3'd7;
            running  <= 1'b1;
         end else if (running) begin
            if (rem >= trial) begin
               rem           <= rem - trial;
               quotient[idx] <= 1'b1;
            end
            if (idx == 3'd0) begin
               running <= 1'b0;
               done    <= 1'b1;
            end else begin
               idx <= idx - 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/luma_class_estimator.sv
// ---------------------------------------------------------------------------
// luma_class_estimator
// Two-class (dark/bright) luma mean estimator. Each frame is split at the
// midpoint of the current means; the per-class averages of the frame become
// the new means (kept ordered class_1 <= class_2).
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   bus   luma_class_estimator_if.slave (pixel stream in, estimate out)
// Timing: last pixel accepted -> DIV_1 (9 cycles) -> DIV_2 (9 cycles) ->
// UPDATE (2 cycles: capture second quotient, then write), so class outputs
// change exactly 20 edges after the last pixel edge.
// ---------------------------------------------------------------------------
module luma_class_estimator
   import luma_class_estimator_pkg::*;
#(
   parameter int          IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int          IMAGE_HIGHT  = DEF_IMAGE_HIGHT,
   parameter logic [7:0]  INIT_CLASS_1 = 8'd64,
   parameter logic [7:0]  INIT_CLASS_2 = 8'd192
)
(
   input logic                   clk,
   input logic                   rst,
   luma_class_estimator_if.slave bus
);

   localparam logic [CNT_W-1:0] FRAME_PIXELS = CNT_W'(IMAGE_WIDTH * IMAGE_HIGHT);

   state_t            state;
   state_t            state_next;
   logic [3:0]        phase;          // cycles spent in the current DIV/UPDATE state

   logic [LUMA_W:0]   t_reg;
   logic [SUM_W-1:0]  sum_1, sum_2;
   logic [CNT_W-1:0]  cnt_1, cnt_2;
   logic [CNT_W-1:0]  pix_cnt;
   logic [LUMA_W-1:0] res_1, res_2;   // candidate means before ordering

   logic [LUMA_W-1:0] class_1_r, class_2_r;
   logic              class_valid_r, converged_r;

   // Pixel acceptance
   logic              restart;
   logic              accept;
   logic [LUMA_W:0]   t_use;
   logic              is_dark;
   logic [CNT_W-1:0]  pix_next;
   logic              last_pixel;

   // Divider hookup
   logic              busy;
   logic              div_start;
   logic [SUM_W-1:0]  div_dividend;
   logic [CNT_W-1:0]  div_divisor;
   logic [LUMA_W-1:0] div_q;
   logic              div_done;

   // Ordered write values
   logic [LUMA_W-1:0] new_lo, new_hi;

   assign restart  = bus.pixel_valid && bus.frame_start &&
                     (state == ST_IDLE || state == ST_ACCUM);
   assign accept   = restart || (bus.pixel_valid && state == ST_ACCUM);
   // A restart pixel is classified with the threshold being latched on the
   // same edge; the means cannot change during ACCUM so both agree.
   assign t_use    = restart ? threshold(class_1_r, class_2_r) : t_reg;
   assign is_dark  = {1'b0, bus.luma_ch} < t_use;
   assign pix_next = restart ? CNT_W'(1) : pix_cnt + CNT_W'(1);
   assign last_pixel = accept && (pix_next == FRAME_PIXELS);

   assign new_lo = (res_1 > res_2) ? res_2 : res_1;
   assign new_hi = (res_1 > res_2) ? res_1 : res_2;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  phase <= '0;
      else if (state_next != state)             phase <= '0;
      else if (state inside {ST_DIV_1, ST_DIV_2, ST_UPDATE})
                                                phase <= phase + 4'd1;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE, ST_ACCUM: begin
            if (last_pixel)   state_next = ST_DIV_1;
            else if (restart) state_next = ST_ACCUM;
         end
         ST_DIV_1:  if (phase == 4'(DIV_HOLD - 1)) state_next = ST_DIV_2;
         ST_DIV_2:  if (phase == 4'(DIV_HOLD - 1)) state_next = ST_UPDATE;
         ST_UPDATE: if (phase == 4'd1)             state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: output logic ----------------
   // An empty class never starts the divider; its candidate keeps the old mean.
   always_comb begin
      busy         = (state != ST_IDLE);
      div_start    = 1'b0;
      div_dividend = sum_1;
      div_divisor  = cnt_1;
      if (state == ST_DIV_1 && phase == 4'd0)
         div_start = (cnt_1 != '0);
      if (state == ST_DIV_2) begin
         div_dividend = sum_2;
         div_divisor  = cnt_2;
         if (phase == 4'd0) div_start = (cnt_2 != '0);
      end
   end

   serial_divider u_divider (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .quotient (div_q),
      .done     (div_done)
   );

   // ---------------- Accumulation ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_reg   <= '0;
         sum_1   <= '0;
         sum_2   <= '0;
         cnt_1   <= '0;
         cnt_2   <= '0;
         pix_cnt <= '0;
      end else if (accept) begin
         pix_cnt <= pix_next;
         if (restart) begin
            t_reg <= t_use;
            sum_1 <= is_dark ? SUM_W'(bus.luma_ch) : '0;
            cnt_1 <= is_dark ? CNT_W'(1) : '0;
            sum_2 <= is_dark ? '0 : SUM_W'(bus.luma_ch);
            cnt_2 <= is_dark ? '0 : CNT_W'(1);
         end else if (is_dark) begin
            sum_1 <= sum_1 + SUM_W'(bus.luma_ch);
            cnt_1 <= cnt_1 + CNT_W'(1);
         end else begin
            sum_2 <= sum_2 + SUM_W'(bus.luma_ch);
            cnt_2 <= cnt_2 + CNT_W'(1);
         end
      end
   end

   // ---------------- Candidates and outputs ----------------
   // A quotient's done pulse lands in the state after its division:
   // DIV_1's in DIV_2, DIV_2's in the first UPDATE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_1         <= INIT_CLASS_1;
         res_2         <= INIT_CLASS_2;
         class_1_r     <= INIT_CLASS_1;
         class_2_r     <= INIT_CLASS_2;
         class_valid_r <= 1'b0;
         converged_r   <= 1'b0;
      end else begin
         if (last_pixel) begin
            res_1 <= class_1_r;
            res_2 <= class_2_r;
         end
         if (div_done && state == ST_DIV_2)  res_1 <= div_q;
         if (div_done && state == ST_UPDATE) res_2 <= div_q;
         if (state == ST_UPDATE && phase == 4'd1) begin
            class_1_r     <= new_lo;
            class_2_r     <= new_hi;
            class_valid_r <= 1'b1;
            converged_r   <= (new_lo == class_1_r) && (new_hi == class_2_r);
         end
      end
   end

   assign bus.class_1     = class_1_r;
   assign bus.class_2     = class_2_r;
   assign bus.class_valid = class_valid_r;
   assign bus.converged   = converged_r;
   assign bus.busy        = busy;

endmodule

// File: tb/tb_luma_class_estimator.sv
// ---------------------------------------------------------------------------
// tb_luma_class_estimator
// Randomised frames checked against a frame-level reference model (threshold,
// per-class integer means, ordering, convergence) kept in the bench.
// A reduced 48x24 image keeps run time short while still allowing a restart
// at pixel 1000.
// ---------------------------------------------------------------------------
module tb_luma_class_estimator;
   import luma_class_estimator_pkg::*;

   localparam int W = 48;
   localparam int H = 24;
   localparam int N = W * H;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   luma_class_estimator_if bus ();

   luma_class_estimator #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HIGHT  (H),
      .INIT_CLASS_1 (8'd64),
      .INIT_CLASS_2 (8'd192)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] px [N];

   // Reference model state
   int m_c1 = 64;
   int m_c2 = 192;
   bit m_valid = 1'b0;
   bit m_conv  = 1'b0;

   // Apply one complete frame (px) to the model.
   task automatic model_frame();
      int t, s1, s2, n1, n2, a, b, tmp;
      t = m_c1 / 2 + m_c2 / 2;
      s1 = 0; s2 = 0; n1 = 0; n2 = 0;
      for (int i = 0; i < N; i++) begin
         if (int'(px[i]) < t) begin s1 += px[i]; n1++; end
         else                 begin s2 += px[i]; n2++; end
      end
      a = (n1 != 0) ? s1 / n1 : m_c1;
      b = (n2 != 0) ? s2 / n2 : m_c2;
      if (a > b) begin tmp = a; a = b; b = tmp; end
      m_conv  = (a == m_c1) && (b == m_c2);
      m_c1    = a;
      m_c2    = b;
      m_valid = 1'b1;
   endtask

   // Drive px as a frame (frame_start on the first pixel). Returns at the
   // negedge right after the edge that accepted the last pixel.
   task automatic stream_frame(input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps && $urandom_range(0, 5) == 0) begin
            bus.pixel_valid = 1'b0;
            bus.frame_start = 1'($urandom);
            bus.luma_ch     = 8'($urandom);
            @(negedge clk);
         end
         bus.pixel_valid = 1'b1;
         bus.frame_start = (i == 0);
         bus.luma_ch     = px[i];
         @(negedge clk);
      end
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   // Wait out the 20-cycle latency: old values must hold through edge 19 and
   // the model values must appear at edge 20. With noise, frame_start pixels
   // are presented throughout and must be ignored.
   task automatic expect_update(input string name, input int old_1, input int old_2,
                                input bit noise);
      for (int k = 1; k <= 20; k++) begin
         if (noise) begin
            bus.pixel_valid = 1'b1;
            bus.frame_start = 1'b1;
            bus.luma_ch     = 8'($urandom);
         end
         @(negedge clk);
         if (k == 19) begin
            total++;
            if (bus.busy !== 1'b1 || bus.class_1 !== 8'(old_1) || bus.class_2 !== 8'(old_2)) begin
               bad++;
               $display("FAIL %s early: busy=%b c1=%0d c2=%0d want busy=1 c1=%0d c2=%0d",
                        name, bus.busy, bus.class_1, bus.class_2, old_1, old_2);
            end
         end
      end
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b0;
      total++;
      if (bus.class_1 !== 8'(m_c1) || bus.class_2 !== 8'(m_c2)) begin
         bad++;
         $display("FAIL %s means: c1=%0d c2=%0d want c1=%0d c2=%0d",
                  name, bus.class_1, bus.class_2, m_c1, m_c2);
      end
      total++;
      if (bus.class_valid !== m_valid || bus.converged !== m_conv || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s flags: valid=%b conv=%b busy=%b want valid=%b conv=%b busy=0",
                  name, bus.class_valid, bus.converged, bus.busy, m_valid, m_conv);
      end
   endtask

   task automatic run_frame(input string name, input bit gaps, input bit noise);
      int o1, o2;
      o1 = m_c1;
      o2 = m_c2;
      model_frame();
      stream_frame(gaps);
      expect_update(name, o1, o2, noise);
   endtask

   // Assert rst between clock edges; outputs must be at reset values at once.
   task automatic pulse_reset(input string name);
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b0;
      #3 rst = 1'b1;
      #1;
      total++;
      if (bus.class_1 !== 8'd64 || bus.class_2 !== 8'd192 || bus.class_valid !== 1'b0 ||
          bus.converged !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: c1=%0d c2=%0d valid=%b conv=%b busy=%b want 64/192/0/0/0",
                  name, bus.class_1, bus.class_2, bus.class_valid, bus.converged, bus.busy);
      end
      m_c1 = 64; m_c2 = 192; m_valid = 1'b0; m_conv = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_random();
      int lo, hi, v;
      lo = $urandom_range(0, 110);
      hi = $urandom_range(130, 255);
      for (int i = 0; i < N; i++) begin
         v = ($urandom_range(0, 1) != 0) ? lo : hi;
         v = v + $urandom_range(0, 40) - 20;
         if (v < 0)   v = 0;
         if (v > 255) v = 255;
         px[i] = 8'(v);
      end
   endtask

   task automatic test_reset();
      pulse_reset("reset_state");
      // Pixels without frame_start in IDLE must not start anything.
      for (int i = 0; i < 20; i++) begin
         bus.pixel_valid = 1'b1;
         bus.frame_start = 1'b0;
         bus.luma_ch     = 8'($urandom);
         @(negedge clk);
      end
      bus.pixel_valid = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.class_1 !== 8'd64 || bus.class_2 !== 8'd192) begin
         bad++;
         $display("FAIL idle_ignore: busy=%b c1=%0d c2=%0d want 0/64/192",
                  bus.busy, bus.class_1, bus.class_2);
      end
   endtask

   task automatic test_uniform();
      pulse_reset("uniform_reset");
      for (int i = 0; i < N; i++) px[i] = 8'd100;
      run_frame("uniform_100", 1'b0, 1'b0);
   endtask

   task automatic test_two_level();
      logic [7:0] tmp;
      int j;
      pulse_reset("two_level_reset");
      for (int i = 0; i < N; i++) px[i] = (i < N / 2) ? 8'd50 : 8'd200;
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = px[i]; px[i] = px[j]; px[j] = tmp;
      end
      run_frame("two_level_1", 1'b1, 1'b0);
      run_frame("two_level_2", 1'b0, 1'b0);
   endtask

   task automatic test_saturate();
      pulse_reset("saturate_reset");
      for (int i = 0; i < N; i++) px[i] = 8'd255;
      run_frame("saturate_255", 1'b0, 1'b0);
   endtask

   task automatic test_restart();
      // 999 pixels of junk, then frame_start on pixel 1000 begins the frame
      // that actually counts.
      for (int i = 0; i < 999; i++) begin
         bus.pixel_valid = 1'b1;
         bus.frame_start = (i == 0);
         bus.luma_ch     = 8'($urandom);
         @(negedge clk);
      end
      fill_random();
      run_frame("restart_1000", 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      fill_random();
      for (int i = 0; i < 500; i++) begin
         bus.pixel_valid = 1'b1;
         bus.frame_start = (i == 0);
         bus.luma_ch     = px[i];
         @(negedge clk);
      end
      pulse_reset("reset_mid_accum");
      fill_random();
      run_frame("after_accum_reset", 1'b1, 1'b0);
      fill_random();
      stream_frame(1'b0);
      repeat (13) @(negedge clk);   // inside DIV_2
      pulse_reset("reset_mid_div2");
      fill_random();
      run_frame("after_div2_reset", 1'b0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      fill_random();
      run_frame("busy_ignore", 1'b0, 1'b1);
      fill_random();
      run_frame("after_busy_ignore", 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         fill_random();
         run_frame($sformatf("random_%0d", f), 1'b1, 1'b0);
      end
      // Repeat the last frame twice more: the estimate should settle.
      run_frame("random_repeat_1", 1'b0, 1'b0);
      run_frame("random_repeat_2", 1'b0, 1'b0);
   endtask

   initial begin
      bus.luma_ch     = '0;
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_uniform();
      test_two_level();
      test_saturate();
      test_restart();
      test_reset_mid();
      test_busy_ignore();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
